// File: rtl/jh_msg_padder.sv
// Feeds the JH-512 core wrapper: forwards a byte-aligned message as 16-bit words,
// then appends 0x80, zero fill and the 128-bit big-endian bit length in whole blocks.
module jh_msg_padder #(
  parameter int W     = 16,
  parameter int WPB   = 32,
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] in_data,
  input  logic [1:0]   in_nbytes,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic         core_init,
  output logic         core_load,
  output logic [W-1:0] core_data,
  input  logic         core_ack,
  output logic         busy,
  output logic         done
);
  localparam int WC_W = $clog2(WPB);
  localparam logic [WC_W-1:0] LAST_POS = WC_W'(WPB - 1);
  localparam logic [WC_W-1:0] LEN_POS  = WC_W'(WPB - 8);
  localparam logic [W-1:0]    PAD80    = {8'h80, {(W-8){1'b0}}};

  typedef enum logic [2:0] {IDLE, INIT, GAP, MSG, SEND, PAD, LEN, FIN} state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      data_q, data_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic              tf_q, tf_d;     // tail seen; remaining words are generated
  logic              pend_q, pend_d; // 0x8000 word still owed
  logic              xb_q, xb_d;     // current block is not the final one
  logic              lp_q, lp_d;     // emitting the length words
  logic              gap_q, gap_d;
  logic [127:0]      bitlen, len_sh;

  assign bitlen = {{(125-LEN_W){1'b0}}, len_q, 3'b000};
  // words 24..31 carry the bit length, most-significant word at 24
  assign len_sh = bitlen >> {~wcnt_q[2:0], 4'b0000};

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    tf_d    = tf_q;
    pend_d  = pend_q;
    xb_d    = xb_q;
    lp_d    = lp_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = INIT;
        len_d   = '0;
        wcnt_d  = '0;
        tf_d    = 1'b0;
        pend_d  = 1'b0;
        xb_d    = 1'b0;
        lp_d    = 1'b0;
        gap_d   = 1'b0;
      end
      INIT: state_d = GAP;
      GAP: begin
        gap_d = 1'b1;
        if (gap_q) state_d = MSG;
      end
      MSG: if (in_valid) begin
        len_d   = len_q + LEN_W'(in_nbytes);
        data_d  = in_data;
        state_d = SEND;
        if (in_last) begin
          tf_d = 1'b1;
          // an unaligned length always pushes the length field into one more block
          xb_d = (len_d[5:0] != 6'd0);
          case (in_nbytes)
            2'd0:    data_d = PAD80;
            2'd1:    data_d = {in_data[W-1:W-8], 8'h80};
            default: pend_d = 1'b1;
          endcase
        end
      end
      SEND: if (core_ack) begin
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == LAST_POS) xb_d = 1'b0;
        if (!tf_q)                            state_d = MSG;
        else if (!lp_q)                       state_d = PAD;
        else if (wcnt_q == LAST_POS)          state_d = FIN;
        else                                  state_d = LEN;
      end
      PAD: begin
        if (wcnt_q == LEN_POS && !xb_q && !pend_q) begin
          lp_d    = 1'b1;
          state_d = LEN;
        end else begin
          data_d  = pend_q ? PAD80 : '0;
          pend_d  = 1'b0;
          state_d = SEND;
        end
      end
      LEN: begin
        data_d  = len_sh[W-1:0];
        state_d = SEND;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      len_q   <= '0;
      wcnt_q  <= '0;
      tf_q    <= 1'b0;
      pend_q  <= 1'b0;
      xb_q    <= 1'b0;
      lp_q    <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      tf_q    <= tf_d;
      pend_q  <= pend_d;
      xb_q    <= xb_d;
      lp_q    <= lp_d;
      gap_q   <= gap_d;
    end
  end

  assign in_ready  = (state_q == MSG);
  assign core_init = (state_q == INIT);
  assign core_load = (state_q == SEND);
  assign core_data = data_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);

endmodule

// File: tb/tb_jh_msg_padder.sv
// Bench for jh_msg_padder: random messages and ack stalls against a byte-level padding model.
module tb_jh_msg_padder;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0] in_data = '0;
  logic [1:0]  in_nbytes = '0;
  logic        in_valid = 1'b0, in_last = 1'b0, core_ack = 1'b0;
  logic        in_ready, core_init, core_load, busy, done;
  logic [15:0] core_data;

  jh_msg_padder dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_nbytes(in_nbytes),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready), .core_init(core_init),
    .core_load(core_load), .core_data(core_data), .core_ack(core_ack), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_pass = 0;
  logic [7:0]  msg[$];
  logic [15:0] exp_q[$], got_q[$];
  int          done_cnt = 0, init_cnt = 0, viol = 0;
  int          ack_min = 0, ack_max = 0, dly = 0, wait_cnt = 0;
  bit          held = 1'b0, prev_acked = 1'b0;
  logic [15:0] held_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] gw(input int i);
    return (i < got_q.size()) ? 32'(got_q[i]) : 32'hdead_beef;
  endfunction

  // Reference: message bytes, 0x80, zeros, then 16-byte big-endian bit length,
  // total rounded to whole 64-byte blocks with at least 64 pad bytes.
  task automatic build_exp();
    int         L;
    int         tot;
    logic [7:0] b[$];
    logic [127:0] bl;
    L   = msg.size();
    tot = 64 * ((L + 63) / 64 + 1);
    b   = msg;
    b.push_back(8'h80);
    while (b.size() < tot - 16) b.push_back(8'h00);
    bl = 128'(L) << 3;
    for (int i = 0; i < 16; i++) b.push_back(bl[127-8*i -: 8]);
    exp_q.delete();
    for (int i = 0; i < tot; i += 2) exp_q.push_back({b[i], b[i+1]});
  endtask

  task automatic rand_msg(input int L);
    msg.delete();
    for (int i = 0; i < L; i++) msg.push_back(8'($urandom));
  endtask

  task automatic ack_cfg(input int a, input int b);
    ack_min = a;
    ack_max = b;
    dly     = int'($urandom_range(a, b));
  endtask

  task automatic send_word(input logic [15:0] d, input logic [1:0] nb, input logic lst,
                           input bit xstart, inout bit ok);
    int c;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    in_valid = 1'b1; in_data = d; in_nbytes = nb; in_last = lst; start = xstart;
    c = 0;
    while (!in_ready && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
      ok = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
  endtask

  task automatic run_msg(input bit tail0, input bit dup_start);
    int L, d0, i0, n;
    bit ok, tail;
    logic lst;
    L    = msg.size();
    tail = tail0 || (L == 0);
    build_exp();
    got_q.delete();
    d0 = done_cnt; i0 = init_cnt; viol = 0; ok = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < L && ok; i += 2) begin
      lst = (i + 2 >= L) && !tail;
      if (i + 1 < L) send_word({msg[i], msg[i+1]}, 2'd2, lst, dup_start && i == 0, ok);
      else           send_word({msg[i], 8'($urandom)}, 2'd1, 1'b1, dup_start && i == 0, ok);
    end
    if (ok && tail) send_word(16'($urandom), 2'd0, 1'b1, dup_start && L == 0, ok);
    for (int c = 0; c < 20000 && done_cnt == d0; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk($sformatf("done_cnt L=%0d", L), 32'(done_cnt - d0), 32'd1);
    chk($sformatf("init_cnt L=%0d", L), 32'(init_cnt - i0), 32'd1);
    chk($sformatf("busy_after L=%0d", L), 32'(busy), 32'd0);
    chk($sformatf("protocol L=%0d", L), 32'(viol), 32'd0);
    chk($sformatf("nwords L=%0d", L), 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("word L=%0d w%0d", L, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  // Wrapper model: random ack latency, records each acknowledged word, polices the handshake.
  always @(negedge clk) begin
    if (rst) begin
      core_ack = 1'b0; held = 1'b0; prev_acked = 1'b0; wait_cnt = 0;
    end else begin
      if (core_init) init_cnt++;
      if (done) begin
        done_cnt++;
        if (!busy) viol++;
      end
      if (prev_acked && core_load) viol++;
      if (core_load) begin
        if (in_ready) viol++;
        if (held && core_data !== held_data) viol++;
        held = 1'b1; held_data = core_data;
        if (wait_cnt >= dly) begin
          core_ack = 1'b1; got_q.push_back(core_data);
          prev_acked = 1'b1; held = 1'b0; wait_cnt = 0;
          dly = int'($urandom_range(ack_min, ack_max));
        end else begin
          core_ack = 1'b0; prev_acked = 1'b0; wait_cnt++;
        end
      end else begin
        core_ack = 1'b0; held = 1'b0; prev_acked = 1'b0;
      end
    end
  end

  initial begin
    bit ok;
    int L;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_core_init", 32'(core_init), 32'd0);
    chk("rst_core_load", 32'(core_load), 32'd0);
    chk("rst_core_data", 32'(core_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    ack_cfg(0, 2);
    msg.delete();
    run_msg(1'b1, 1'b0);
    chk("empty_w0", gw(0), 32'h8000);
    chk("empty_w31", gw(31), 32'h0000);

    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    run_msg(1'b0, 1'b0);
    chk("abc_w0", gw(0), 32'h6162);
    chk("abc_w1", gw(1), 32'h6380);
    chk("abc_w63", gw(63), 32'h0018);

    rand_msg(64);
    run_msg(1'b0, 1'b0);
    chk("m64_w32", gw(32), 32'h8000);
    chk("m64_w63", gw(63), 32'h0200);

    rand_msg(62);
    run_msg(1'b0, 1'b1);
    chk("m62_w30", gw(30), 32'({msg[60], msg[61]}));
    chk("m62_w31", gw(31), 32'h8000);
    chk("m62_w63", gw(63), 32'h01f0);

    ack_cfg(5, 5);
    rand_msg(40);
    run_msg(1'b0, 1'b0);

    ack_cfg(0, 3);
    for (int k = 0; k < 8; k++) begin
      L = int'($urandom_range(0, 140));
      rand_msg(L);
      run_msg((L % 2 == 0) && ($urandom_range(0, 1) == 1), k == 3);
    end

    // reset while a word is held waiting for ack, two words into the block
    ack_cfg(20, 20);
    rand_msg(30);
    got_q.delete();
    ok = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3; i++) send_word({msg[2*i], msg[2*i+1]}, 2'd2, 1'b0, 1'b0, ok);
    chk("pre_rst_load", 32'(core_load), 32'd1);
    chk("pre_rst_nwords", 32'(got_q.size()), 32'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_core_load", 32'(core_load), 32'd0);
    chk("mid_rst_core_data", 32'(core_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_init_done", 32'({core_init, done}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ack_cfg(0, 2);
    msg.delete();
    run_msg(1'b1, 1'b0);
    chk("post_rst_w0", gw(0), 32'h8000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
